// File: rtl/gpioemu_mulpop_if.sv
// Emulated register bus between a host and the gpioemu_mulpop peripheral:
// level strobes srd/swr, a 16-bit address and 32-bit data in each direction.
interface gpioemu_mulpop_if;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_in;
   logic [31:0] sdata_out;

   modport master (output saddress, srd, swr, sdata_in, input sdata_out);
   modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/gpioemu_mulpop.sv
// Sequential shift-add multiplier with a popcount of the truncated product, behind the srd/swr bus.
// Define GPIOEMU_MULPOP_RADIX4_EN to retire two multiplier bits per MULT cycle instead of one.
module gpioemu_mulpop #(
   parameter int          OP_W  = 24,
   parameter int          RES_W = 32,
   parameter int          CNT_W = 32,
   parameter logic [15:0] BASE  = 16'h0380
) (
   input  logic             clk,
   input  logic             reset,
   gpioemu_mulpop_if.slave  bus,
   input  logic [31:0]      gpio_in,
   input  logic             gpio_latch,
   output logic [31:0]      gpio_in_s_insp,
   output logic [CNT_W-1:0] gpio_out
);
`ifdef GPIOEMU_MULPOP_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int ITER = (OP_W + STEP - 1) / STEP;
   // Accumulator is wide enough both for the full product and for the RES_W slice.
   localparam int AW = (2 * OP_W > RES_W) ? 2 * OP_W : RES_W;
   localparam int IW = $clog2(ITER + 1);
   localparam int LW = $clog2(RES_W + 1);

   localparam logic [15:0] ADDR_A1   = BASE;
   localparam logic [15:0] ADDR_A2   = BASE + 16'h0008;
   localparam logic [15:0] ADDR_W    = BASE + 16'h0010;
   localparam logic [15:0] ADDR_L    = BASE + 16'h0018;
   localparam logic [15:0] ADDR_CTRL = BASE + 16'h0020;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_COUNT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              srd_q, swr_q, latch_q;
   logic              rd_edge, wr_edge, latch_edge, start;
   logic [OP_W-1:0]   a1, a2, mr;
   logic [RES_W-1:0]  w_reg;
   logic [LW-1:0]     l_reg;
   logic              valid, done, busy, err;
   logic [AW-1:0]     acc, mc;
   logic [IW-1:0]     iter;
   logic [31:0]       rd_data;

   function automatic logic [LW-1:0] popcount(input logic [RES_W-1:0] v);
      logic [LW-1:0] n;
      n = '0;
      for (int i = 0; i < RES_W; i++) n = n + LW'(v[i]);
      return n;
   endfunction

   function automatic logic fits(input logic [AW-1:0] v);
      return (v >> RES_W) == '0;
   endfunction

   function automatic logic [AW-1:0] mult_step(input logic [AW-1:0] a, input logic [AW-1:0] m,
                                                input logic [OP_W-1:0] b);
      logic [AW-1:0] s;
      s = a;
      if (b[0]) s = s + m;
`ifdef GPIOEMU_MULPOP_RADIX4_EN
      if (b[1]) s = s + (m << 1);
`endif
      return s;
   endfunction

   assign rd_edge    = bus.srd & ~srd_q;
   assign wr_edge    = bus.swr & ~swr_q;
   assign latch_edge = gpio_latch & ~latch_q;
   assign start      = wr_edge && (bus.saddress == ADDR_CTRL) && (state_q == S_IDLE);

   generate
      if (OP_W < 32) begin : g_pad
         logic unused_hi;
         assign unused_hi = ^bus.sdata_in[31:OP_W];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_MULT;
         S_MULT:  if (iter == IW'(ITER - 1)) state_d = S_COUNT;
         S_COUNT: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      case (bus.saddress)
         ADDR_A1:   rd_data = 32'(a1);
         ADDR_A2:   rd_data = 32'(a2);
         ADDR_W:    rd_data = 32'(w_reg);
         ADDR_L:    rd_data = 32'(l_reg);
         ADDR_CTRL: rd_data = {28'b0, err, busy, done, valid};
         default:   rd_data = '0;
      endcase
   end

   // Control, bus registers and results; strobe history follows the pins even in reset
   always_ff @(posedge clk) begin
      srd_q   <= bus.srd;
      swr_q   <= bus.swr;
      latch_q <= gpio_latch;
      if (reset) begin
         state_q        <= S_IDLE;
         a1             <= '0;
         a2             <= '0;
         w_reg          <= '0;
         l_reg          <= '0;
         valid          <= 1'b1;
         done           <= 1'b1;
         busy           <= 1'b0;
         err            <= 1'b0;
         bus.sdata_out  <= '0;
         gpio_out       <= '0;
         gpio_in_s_insp <= '0;
      end else begin
         state_q <= state_d;
         if (rd_edge) bus.sdata_out <= rd_data;
         if (latch_edge) gpio_in_s_insp <= gpio_in;
         if (wr_edge && (bus.saddress == ADDR_A1 || bus.saddress == ADDR_A2)) begin
            if (busy) err <= 1'b1;
            else if (bus.saddress == ADDR_A1) a1 <= bus.sdata_in[OP_W-1:0];
            else a2 <= bus.sdata_in[OP_W-1:0];
         end
         if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (state_q == S_COUNT) begin
            w_reg <= acc[RES_W-1:0];
            valid <= fits(acc);
            l_reg <= popcount(acc[RES_W-1:0]);
         end
         if (state_q == S_DONE) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            gpio_out <= gpio_out + CNT_W'(1);
         end
      end
   end

   // Shift-add datapath, only meaningful between LOAD and COUNT
   always_ff @(posedge clk) begin
      case (state_q)
         S_LOAD: begin
            acc  <= '0;
            mc   <= AW'(a1);
            mr   <= a2;
            iter <= '0;
         end
         S_MULT: begin
            acc  <= mult_step(acc, mc, mr);
            mc   <= mc << STEP;
            mr   <= mr >> STEP;
            iter <= iter + IW'(1);
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Bench for gpioemu_mulpop: vector table of multiply jobs plus hand-written sequences
// for abort, mid-operation writes, bus corner cases and the GPIO latch.
module tb_gpioemu_mulpop;
   localparam logic [15:0] A_A1   = 16'h0380;
   localparam logic [15:0] A_A2   = 16'h0388;
   localparam logic [15:0] A_W    = 16'h0390;
   localparam logic [15:0] A_L    = 16'h0398;
   localparam logic [15:0] A_CTRL = 16'h03A0;
   localparam logic [15:0] A_NONE = 16'h03A8;
`ifdef GPIOEMU_MULPOP_RADIX4_EN
   localparam int LAT = 15;
`else
   localparam int LAT = 27;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] gpio_in;
   logic        gpio_latch;
   logic [31:0] gpio_in_s_insp;
   logic [31:0] gpio_out;

   gpioemu_mulpop_if bus ();

   gpioemu_mulpop dut (
      .clk(clk), .reset(reset), .bus(bus),
      .gpio_in(gpio_in), .gpio_latch(gpio_latch),
      .gpio_in_s_insp(gpio_in_s_insp), .gpio_out(gpio_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] addr;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [31:0] w;
      logic [31:0] l;
      logic [31:0] st;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[7];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
      bus.saddress = addr;
      bus.sdata_in = data;
      bus.swr = 1'b1;
      tick();
      bus.swr = 1'b0;
      tick();
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
      bus.saddress = addr;
      bus.srd = 1'b1;
      tick();
      data = bus.sdata_out;
      bus.srd = 1'b0;
      tick();
   endtask

   task automatic expect_rd(input string name, input logic [15:0] addr, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.addr = addr;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] d;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         bus_read(e.addr, d);
         check(e.name, d, e.val);
      end
   endtask

   // Called one cycle after the start edge; returns cycles from start edge to counter bump.
   task automatic wait_done(input logic [31:0] old, output int n);
      n = 1;
      while (gpio_out == old && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] old;
      int n;

      vecs[0] = '{32'h0, 32'h123, 32'h0, 32'd0, 32'h3};
      vecs[1] = '{32'hFF000003, 32'h5, 32'hF, 32'd4, 32'h3};
      vecs[2] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFE000001, 32'd8, 32'h2};
      vecs[3] = '{32'h10000, 32'h10000, 32'h0, 32'd0, 32'h2};
      vecs[4] = '{32'hFFFF, 32'h10001, 32'hFFFFFFFF, 32'd32, 32'h3};
      vecs[5] = '{32'h800000, 32'h2, 32'h01000000, 32'd1, 32'h3};
      vecs[6] = '{32'hABCDEF, 32'h1, 32'hABCDEF, 32'd17, 32'h3};

      reset = 1'b1;
      bus.saddress = '0;
      bus.sdata_in = '0;
      bus.srd = 1'b0;
      bus.swr = 1'b0;
      gpio_in = '0;
      gpio_latch = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_insp", gpio_in_s_insp, 32'h0);
      check("rst_sdata_out", bus.sdata_out, 32'h0);
      expect_rd("rst_status", A_CTRL, 32'h3);
      expect_rd("rst_w", A_W, 32'h0);
      expect_rd("rst_l", A_L, 32'h0);
      drain();

      // Abort an operation with reset partway through MULT
      bus_write(A_A1, 32'h5);
      bus_write(A_A2, 32'h7);
      bus_write(A_CTRL, 32'h0);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_gpio_out", gpio_out, 32'h0);
      expect_rd("abort_status", A_CTRL, 32'h3);
      expect_rd("abort_w", A_W, 32'h0);
      expect_rd("abort_a1", A_A1, 32'h0);
      drain();
      repeat (40) tick();
      check("abort_no_incr", gpio_out, 32'h0);

      for (int i = 0; i < 7; i++) begin
         bus_write(A_A1, vecs[i].a1);
         bus_write(A_A2, vecs[i].a2);
         old = gpio_out;
         exp_cnt = exp_cnt + 1;
         expect_rd($sformatf("vec%0d_w", i), A_W, vecs[i].w);
         expect_rd($sformatf("vec%0d_l", i), A_L, vecs[i].l);
         expect_rd($sformatf("vec%0d_status", i), A_CTRL, vecs[i].st);
         bus_write(A_CTRL, 32'h0);
         wait_done(old, n);
         check($sformatf("vec%0d_latency", i), n, LAT);
         check($sformatf("vec%0d_gpio_out", i), gpio_out, exp_cnt);
         drain();
      end

      // Writes to W and unmapped space are ignored; reads hold until the next srd edge
      bus_write(A_W, 32'hDEADBEEF);
      bus_write(A_NONE, 32'h12345678);
      expect_rd("w_after_ro_write", A_W, 32'hABCDEF);
      expect_rd("unmapped_read", A_NONE, 32'h0);
      drain();
      bus.saddress = A_W;
      repeat (3) tick();
      check("sdata_out_hold", bus.sdata_out, 32'h0);
      check("ro_write_no_start", gpio_out, exp_cnt);

      // Simultaneous read and write of A1 returns the old value
      bus_write(A_A1, 32'hFF0ABCDE);
      bus.saddress = A_A1;
      bus.sdata_in = 32'h111;
      bus.srd = 1'b1;
      bus.swr = 1'b1;
      tick();
      check("rw_same_cycle_old", bus.sdata_out, 32'h0ABCDE);
      bus.srd = 1'b0;
      bus.swr = 1'b0;
      tick();
      expect_rd("rw_same_cycle_new", A_A1, 32'h111);
      drain();

      // Operand write and restart during busy
      bus_write(A_A1, 32'h6);
      bus_write(A_A2, 32'h5);
      old = gpio_out;
      exp_cnt = exp_cnt + 1;
      bus_write(A_CTRL, 32'h0);
      bus_write(A_A1, 32'h7);
      bus_write(A_CTRL, 32'h0);
      bus_read(A_CTRL, d);
      check("busy_err_status", d, 32'hD);
      n = 7;
      while (gpio_out == old && n < 200) begin
         tick();
         n++;
      end
      check("busy_latency", n, LAT);
      expect_rd("busy_w", A_W, 32'd30);
      expect_rd("busy_l", A_L, 32'd4);
      expect_rd("busy_done_status", A_CTRL, 32'hB);
      expect_rd("busy_a1_kept", A_A1, 32'h6);
      drain();
      repeat (40) tick();
      check("busy_single_incr", gpio_out, exp_cnt);

      // GPIO latch on the rising edge only
      gpio_in = 32'hA5A5A5A5;
      tick();
      check("latch_before", gpio_in_s_insp, 32'h0);
      gpio_latch = 1'b1;
      tick();
      check("latch_edge", gpio_in_s_insp, 32'hA5A5A5A5);
      gpio_latch = 1'b0;
      gpio_in = 32'h12345678;
      repeat (2) tick();
      check("latch_no_edge", gpio_in_s_insp, 32'hA5A5A5A5);
      gpio_latch = 1'b1;
      tick();
      check("latch_edge2", gpio_in_s_insp, 32'h12345678);
      gpio_in = 32'hFFFF0000;
      repeat (2) tick();
      check("latch_level_held", gpio_in_s_insp, 32'h12345678);
      gpio_latch = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
